// File: rtl/nibble_serial_adder_if.sv
// Bundles the controller handshake/operand bus and the external 4-bit CLA slice hookup.
// NSA_OVERFLOW_EN adds the Ovf result flag.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef NSA_OVERFLOW_EN
  logic             Ovf;
`endif
  logic [3:0]       Slice_A;
  logic [3:0]       Slice_B;
  logic             Slice_Cin;
  logic [3:0]       Slice_S;
  logic             Slice_Cout;

`ifdef NSA_OVERFLOW_EN
  modport slave (
    input  Start, A, B, Cin, Slice_S, Slice_Cout,
    output Busy, Done, Sum, Cout, Ovf, Slice_A, Slice_B, Slice_Cin
  );
  modport master (
    output Start, A, B, Cin, Slice_S, Slice_Cout,
    input  Busy, Done, Sum, Cout, Ovf, Slice_A, Slice_B, Slice_Cin
  );
`else
  modport slave (
    input  Start, A, B, Cin, Slice_S, Slice_Cout,
    output Busy, Done, Sum, Cout, Slice_A, Slice_B, Slice_Cin
  );
  modport master (
    output Start, A, B, Cin, Slice_S, Slice_Cout,
    input  Busy, Done, Sum, Cout, Slice_A, Slice_B, Slice_Cin
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one external 4-bit CLA slice, LSB nibble first.
// Optional registered two's-complement overflow flag under NSA_OVERFLOW_EN.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  nibble_serial_adder_if.slave  bus_io
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef NSA_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
`ifdef NSA_OVERFLOW_EN
    ovf_d     = ovf_q;
`endif
    bus_io.Slice_A   = 4'h0;
    bus_io.Slice_B   = 4'h0;
    bus_io.Slice_Cin = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.Start) begin
          op_a_d  = bus_io.A;
          op_b_d  = bus_io.B;
          carry_d = bus_io.Cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CntW'(i)) begin
            bus_io.Slice_A      = op_a_q[4*i +: 4];
            bus_io.Slice_B      = op_b_q[4*i +: 4];
            acc_d[4*i +: 4]     = bus_io.Slice_S;
          end
        end
        bus_io.Slice_Cin = carry_q;
        carry_d          = bus_io.Slice_Cout;
        if (cnt_q == CntW'(NIBBLES - 1)) begin
          // acc_d already holds the final nibble, so the result is complete here.
          sum_d   = acc_d;
          cout_d  = bus_io.Slice_Cout;
`ifdef NSA_OVERFLOW_EN
          ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (acc_d[WIDTH-1] != op_a_q[WIDTH-1]);
`endif
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NSA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus_io.Busy = busy_q;
  assign bus_io.Done = done_q;
  assign bus_io.Sum  = sum_q;
  assign bus_io.Cout = cout_q;
`ifdef NSA_OVERFLOW_EN
  assign bus_io.Ovf  = ovf_q;
`endif

endmodule
